// File: rtl/pattern_reader.sv
// pattern_reader: detects a programmable BLANK-framed symbol sequence on bits, pulsing match per occurrence.
// Optional saturating match counter enabled by defining PATTERN_READER_COUNT_EN.
module pattern_reader #(
   parameter int                           SYM_W   = 2,
   parameter int                           MAX_LEN = 8,
   parameter logic [SYM_W-1:0]             BLANK   = '0,
   parameter int                           DEF_LEN = 1,
   parameter logic [MAX_LEN*SYM_W-1:0]     DEF_PAT = 3,
   parameter int                           CNT_W   = 8
) (
   input  logic                             clk,
   input  logic                             restart,
   input  logic [SYM_W-1:0]                 bits,
   input  logic                             pat_load,
   input  logic [$clog2(MAX_LEN+1)-1:0]     pat_len,
   input  logic [MAX_LEN*SYM_W-1:0]         pat_data,
   output logic                             match,
   output logic                             bad_load,
   output logic [CNT_W-1:0]                 match_cnt
);
   localparam int LW = $clog2(MAX_LEN+1);
   typedef enum logic {WAIT_BLANK, TRACK} state_t;
   state_t                         state;
   logic [MAX_LEN-1:0][SYM_W-1:0]  pat;
   logic [LW-1:0]                  len, pos;
   logic [SYM_W-1:0]               cur;
   logic                           ok, hit;
   always_comb begin
      cur = BLANK;
      for (int k = 0; k < MAX_LEN; k++)
         if (pos == LW'(k)) cur = pat[k];
   end
   assign ok  = pat_len != '0 && pat_len <= LW'(MAX_LEN);
   assign hit = !restart && !pat_load && state == TRACK && pos == len && bits == BLANK;
   always_ff @(posedge clk) begin
      if (restart) begin
         state    <= WAIT_BLANK;
         pos      <= '0;
         pat      <= DEF_PAT;
         len      <= LW'(DEF_LEN);
         match    <= 1'b0;
         bad_load <= 1'b0;
      end else begin
         match    <= hit;
         bad_load <= pat_load && !ok;
         if (pat_load) begin
            if (ok) begin
               pat   <= pat_data;
               len   <= pat_len;
               state <= WAIT_BLANK;
               pos   <= '0;
            end
         end else if (state == WAIT_BLANK) begin
            if (bits == BLANK) begin
               state <= TRACK;
               pos   <= '0;
            end
         end else if (pos != len) begin
            // pattern compare has priority, so BLANK may appear inside a pattern
            if (bits == cur) pos <= pos + 1'b1;
            else if (bits == BLANK) pos <= '0;
            else state <= WAIT_BLANK;
         end else if (bits == BLANK) begin
            pos <= '0;
         end else begin
            state <= WAIT_BLANK;
         end
      end
   end
`ifdef PATTERN_READER_COUNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (restart || (pat_load && ok)) cnt <= '0;
      else if (hit && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_pattern_reader.sv
// tb_pattern_reader: directed self-checking bench for pattern_reader (SYM_W=2, MAX_LEN=8, CNT_W=2).
module tb_pattern_reader;
   logic        clk = 1'b0;
   logic        restart, pat_load, match, bad_load;
   logic [1:0]  bits, match_cnt;
   logic [3:0]  pat_len;
   logic [15:0] pat_data;
   int          errors = 0, checks = 0;

   pattern_reader #(.CNT_W(2)) dut (
      .clk(clk), .restart(restart), .bits(bits), .pat_load(pat_load),
      .pat_len(pat_len), .pat_data(pat_data), .match(match),
      .bad_load(bad_load), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // drive one symbol, then check outputs just after the edge that sampled it
   task automatic step(input string tag, input logic [1:0] s, input logic m, input logic b, input int c);
      bits = s;
      @(posedge clk);
      #1;
      chk({tag, ".match"}, 32'(match), 32'(m));
      chk({tag, ".bad_load"}, 32'(bad_load), 32'(b));
`ifdef PATTERN_READER_COUNT_EN
      chk({tag, ".cnt"}, 32'(match_cnt), 32'(c));
`else
      chk({tag, ".cnt"}, 32'(match_cnt), 32'd0);
`endif
   endtask

   initial begin
      restart = 1'b1; pat_load = 1'b0; pat_len = '0; pat_data = '0; bits = 2'b00;
      // 1: bits ignored during restart, then a single I
      step("rst0", 2'b00, 0, 0, 0);
      step("rst1", 2'b11, 0, 0, 0);
      step("rst2", 2'b00, 0, 0, 0);
      restart = 1'b0;
      step("t1a", 2'b00, 0, 0, 0);
      step("t1b", 2'b11, 0, 0, 0);
      step("t1c", 2'b00, 1, 0, 1);
      // 2: extended pattern does not match
      step("t2a", 2'b00, 0, 0, 1);
      step("t2b", 2'b11, 0, 0, 1);
      step("t2c", 2'b11, 0, 0, 1);
      step("t2d", 2'b00, 0, 0, 1);
      // 3: shared blank gives back-to-back matches
      step("t3a", 2'b00, 0, 0, 1);
      step("t3b", 2'b11, 0, 0, 1);
      step("t3c", 2'b00, 1, 0, 2);
      step("t3d", 2'b11, 0, 0, 2);
      step("t3e", 2'b00, 1, 0, 3);
      // 4: three-symbol pattern {01,10,11}
      pat_load = 1'b1; pat_len = 4'd3; pat_data = 16'h0039;
      step("t4ld", 2'b11, 0, 0, 0);
      pat_load = 1'b0;
      step("t4a", 2'b00, 0, 0, 0);
      step("t4b", 2'b01, 0, 0, 0);
      step("t4c", 2'b10, 0, 0, 0);
      step("t4d", 2'b11, 0, 0, 0);
      step("t4e", 2'b00, 1, 0, 1);
      step("t4f", 2'b01, 0, 0, 1);
      step("t4g", 2'b10, 0, 0, 1);
      step("t4h", 2'b00, 0, 0, 1);
      // pattern {00,11}: an in-pattern BLANK is matched as a symbol
      pat_load = 1'b1; pat_len = 4'd2; pat_data = 16'h000C;
      step("pbld", 2'b00, 0, 0, 0);
      pat_load = 1'b0;
      step("pba", 2'b00, 0, 0, 0);
      step("pbb", 2'b00, 0, 0, 0);
      step("pbc", 2'b11, 0, 0, 0);
      step("pbd", 2'b00, 1, 0, 1);
      // 5: rejected loads keep pattern, state and count
      restart = 1'b1;
      step("t5r", 2'b11, 0, 0, 0);
      restart = 1'b0;
      pat_load = 1'b1; pat_len = 4'd0;
      step("t5z", 2'b00, 0, 1, 0);
      pat_len = 4'd9;
      step("t5o", 2'b00, 0, 1, 0);
      pat_load = 1'b0;
      step("t5a", 2'b00, 0, 0, 0);
      step("t5b", 2'b11, 0, 0, 0);
      step("t5c", 2'b00, 1, 0, 1);
      pat_load = 1'b1; pat_len = 4'd0;
      step("t5bad", 2'b11, 0, 1, 1);
      pat_load = 1'b0;
      step("t5d", 2'b11, 0, 0, 1);
      step("t5e", 2'b00, 1, 0, 2);
      // 6: reset mid-sequence discards progress, then saturation
      step("t6a", 2'b00, 0, 0, 2);
      step("t6b", 2'b11, 0, 0, 2);
      restart = 1'b1;
      step("t6r", 2'b00, 0, 0, 0);
      restart = 1'b0;
      step("t6c", 2'b00, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step("sat1", 2'b11, 0, 0, (i < 3) ? i : 3);
         step("sat0", 2'b00, 1, 0, (i + 1 < 3) ? i + 1 : 3);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
